waveform_dig_core: RTL and testbench
====================================

Name: waveform_dig_core

Overview:
- UART-controlled register core for the waveform generator digital block.
- Receives 3-byte command frames over a UART serial line, 8N1 format.
- Command 0x01 writes an 8-bit register; command 0x02 reads a register back as one UART byte.
- Register 0 is driven continuously onto debug_o for bring-up visibility.

Parameters:
- DIVISOR, 16'd326: clk cycles per 16x-oversample tick. At 50 MHz this gives about 9600 baud; bit period = 16*DIVISOR clocks.
- NUM_REGS, 16: number of 8-bit registers; address width is clog2(NUM_REGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_raw  in  1  asynchronous, active-high reset.
- rx_i  in  1  UART receive line, idle high.
- tx_o  out  1  UART transmit line, idle high.
- debug_o  out  8  current value of register 0.

Behaviour:
- Reset:
  - rst_raw asserts asynchronously; internally it is released through a 2-flop synchronizer.
  - While in reset: tx_o=1, debug_o=0x00, all registers 0x00, parser at first-byte state, UART RX/TX idle.
- Baud tick: counter wraps at DIVISOR-1 and issues a 1-clk tick, i.e. 16 ticks per bit.
- UART RX:
  - rx_i passes through a 2-flop synchronizer.
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at tick 8; if it is high, the frame is a false start and RX returns to idle.
  - 8 data bits are then sampled at 16-tick spacing, LSB first.
  - Stop bit is sampled at mid-bit. If high: 1-clk rx_valid with the data byte. If low: byte discarded, no rx_valid.
- UART TX:
  - tx_start with a byte while idle sends start(0), 8 data bits LSB first, stop(1), each 16 ticks long.
  - tx_busy is high for the whole frame.
  - A tx_start while busy is ignored.
- Command parser FSM: states BYTE0 -> BYTE1 -> BYTE2 -> EXEC -> BYTE0, advancing on each rx_valid.
  - BYTE0 latches cmd, BYTE1 latches addr, BYTE2 latches data.
  - EXEC lasts 1 clk:
    - cmd 0x01: reg[addr] <= data.
    - cmd 0x02: the data byte is ignored; reg[addr] is sent on TX. TX starts 1 clk after EXEC if TX is idle; otherwise EXEC waits until TX is idle.
    - Any other cmd: no action, frame consumed.
  - addr >= NUM_REGS: writes dropped, reads return 0x00.
  - No inter-byte timeout; framing stays strictly in counts of 3 bytes from reset.
- debug_o = reg[0], registered, updates 1 clk after EXEC of a write to addr 0.
- A read of a register in the same EXEC as a write is not possible, since there is one command per frame.
- Latency:
  - Write: stop-bit sample of byte 2 -> register update in 2 clks.
  - Read: first tx_o start-bit edge within 3 clks of byte-2 stop sample.
- Reset mid-frame aborts RX, TX and the parser. tx_o returns high immediately.

Decomposition:
- Package waveform_dig_pkg:
  - cmd constants CMD_WRITE=8'h01, CMD_READ=8'h02
  - parser state enum
  - default DIVISOR and NUM_REGS
- One sub-module, waveform_uart (baud tick, RX, TX), with interface:
  - rx_i, tx_o
  - rx_data, rx_valid
  - tx_data, tx_start, tx_busy
- The parser, register file and reset synchronizer live in waveform_dig_core.

Test Plan:
- Reset held 1 us -> tx_o=1, debug_o=0x00 throughout; no TX activity.
- Send 0x01,0x00,0xA1 at DIVISOR 326 -> debug_o=0xA1 (161) within 2 clks of the third stop bit; tx_o stays high.
- Then send 0x02,0x00,0x00 -> exactly one byte 0xA1 is sent on tx_o (10 bits of 5216 clks each); external UART rx_done pulses; debug_o still 0xA1.
- Write 0x5C to addr 0x03, then read addr 0x03 -> response 0x5C. Read addr 0x20 -> response 0x00; debug_o unchanged.
- Send 0x07,0x00,0xFF, then 0x02,0x00,0x00 -> unknown cmd has no effect; response equals the prior reg[0].
- Send a byte with stop bit forced low -> byte dropped, parser state unchanged; the next valid 3-byte write succeeds. Assert rst_raw mid-frame -> tx_o=1 and debug_o=0x00 immediately.

Source files
------------

// File: rtl/waveform_dig_pkg.sv
// Shared constants and state encodings for the waveform generator UART register core.
package waveform_dig_pkg;
  localparam logic [7:0]  CMD_WRITE    = 8'h01;
  localparam logic [7:0]  CMD_READ     = 8'h02;
  localparam logic [15:0] DEF_DIVISOR  = 16'd326;
  localparam int          DEF_NUM_REGS = 16;

  typedef enum logic [1:0] {P_BYTE0, P_BYTE1, P_BYTE2, P_EXEC} parse_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/waveform_uart.sv
// 8N1 UART: shared 16x-oversample baud tick, receiver with false-start rejection, transmitter.
module waveform_uart
  import waveform_dig_pkg::*;
#(
  parameter logic [15:0] DIVISOR = DEF_DIVISOR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy
);
  logic [15:0] baud_cnt;
  logic        tick;

  logic        rx_meta, rx_s, rx_prev;
  rx_state_t   rx_state, rx_state_n;
  logic [3:0]  rx_tcnt, rx_tcnt_n;
  logic [2:0]  rx_bcnt, rx_bcnt_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_valid_n;

  logic        tx_reg;
  logic [3:0]  tx_tcnt;
  logic [3:0]  tx_bcnt;
  logic [8:0]  tx_shift;

  assign tick = (baud_cnt == DIVISOR - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Start bit checked after 8 ticks (mid-bit); every later sample is 16 ticks on.
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bcnt_n  = rx_bcnt;
    rx_shift_n = rx_shift;
    rx_valid_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_n = RX_START;
          rx_tcnt_n  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n  = '0;
            rx_bcnt_n  = '0;
            rx_state_n = rx_s ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift_n = {rx_s, rx_shift[7:1]};
            rx_bcnt_n  = rx_bcnt + 3'd1;
            if (rx_bcnt == 3'd7) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_state_n = RX_IDLE;
            rx_valid_n = rx_s;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bcnt  <= rx_bcnt_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_ff @(posedge clk) rx_shift <= rx_shift_n;

  assign rx_data = rx_shift;

  // tx_bcnt 0 is the start bit, 1..8 data, 9 stop; tx_o is driven straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy <= 1'b0;
      tx_reg  <= 1'b1;
      tx_tcnt <= '0;
      tx_bcnt <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx_busy <= 1'b1;
        tx_reg  <= 1'b0;
        tx_tcnt <= '0;
        tx_bcnt <= '0;
      end
    end else if (tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_tcnt == 4'd15) begin
        if (tx_bcnt == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          tx_reg  <= tx_shift[0];
          tx_bcnt <= tx_bcnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!tx_busy && tx_start)                        tx_shift <= {1'b1, tx_data};
    else if (tx_busy && tick && (tx_tcnt == 4'd15)) tx_shift <= {1'b1, tx_shift[8:1]};
  end

  assign tx_o = tx_reg;
endmodule

// File: rtl/waveform_dig_core.sv
// UART-controlled register file: 3-byte frames {cmd, addr, data} write or read 8-bit registers.
module waveform_dig_core
  import waveform_dig_pkg::*;
#(
  parameter logic [15:0] DIVISOR  = DEF_DIVISOR,
  parameter int          NUM_REGS = DEF_NUM_REGS
) (
  input  logic       clk,
  input  logic       rst_raw,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] debug_o
);
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic         rst_meta, rst;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         tx_start, tx_busy;
  logic [7:0]   rd_byte;
  parse_state_t state, state_n;
  logic [7:0]   cmd, addr, data;
  logic         addr_ok, wr_en;
  logic [7:0]   regs [NUM_REGS];

  // Reset asserts immediately, releases two clocks after rst_raw drops.
  always_ff @(posedge clk or posedge rst_raw) begin
    if (rst_raw) begin
      rst_meta <= 1'b1;
      rst      <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst      <= rst_meta;
    end
  end

  waveform_uart #(.DIVISOR(DIVISOR)) u_uart (
    .clk      (clk),
    .rst      (rst),
    .rx_i     (rx_i),
    .tx_o     (tx_o),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (rd_byte),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  assign addr_ok = ({24'd0, addr} < 32'(NUM_REGS));
  assign rd_byte = addr_ok ? regs[addr[AW-1:0]] : 8'h00;

  // A read holds EXEC until the transmitter is free so the response is never dropped.
  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    wr_en    = 1'b0;
    case (state)
      P_BYTE0: if (rx_valid) state_n = P_BYTE1;
      P_BYTE1: if (rx_valid) state_n = P_BYTE2;
      P_BYTE2: if (rx_valid) state_n = P_EXEC;
      P_EXEC: begin
        if (cmd == CMD_READ) begin
          if (!tx_busy) begin
            tx_start = 1'b1;
            state_n  = P_BYTE0;
          end
        end else begin
          wr_en   = (cmd == CMD_WRITE) && addr_ok;
          state_n = P_BYTE0;
        end
      end
      default: state_n = P_BYTE0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= P_BYTE0;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rx_valid) begin
      case (state)
        P_BYTE0: cmd  <= rx_data;
        P_BYTE1: addr <= rx_data;
        P_BYTE2: data <= rx_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (wr_en) begin
      regs[addr[AW-1:0]] <= data;
    end
  end

  assign debug_o = regs[0];
endmodule

// File: tb/tb_waveform_dig_core.sv
// Bench for waveform_dig_core: bit-banged UART commands against a register-array reference model.
module tb_waveform_dig_core;
  localparam logic [15:0] DIV   = 16'd3;
  localparam int          BIT   = 16 * 3;
  localparam int          NREGS = 16;

  logic       clk = 1'b0;
  logic       rst_raw;
  logic       rx_i;
  logic       tx_o;
  logic [7:0] debug_o;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         tx_edges = 0;
  logic [7:0] model [NREGS];
  logic [8:0] rxq [$];
  logic       mon_prev;
  logic [7:0] mon_b;
  logic       mon_st;

  always #5 clk = ~clk;

  waveform_dig_core #(.DIVISOR(DIV), .NUM_REGS(NREGS)) dut (
    .clk     (clk),
    .rst_raw (rst_raw),
    .rx_i    (rx_i),
    .tx_o    (tx_o),
    .debug_o (debug_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent UART receiver on tx_o: mid-bit sampling, pushes {stop, data}.
  initial begin
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_prev && !tx_o) begin
        tx_edges++;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          mon_b[i] = tx_o;
        end
        repeat (BIT) @(negedge clk);
        mon_st = tx_o;
        rxq.push_back({mon_st, mon_b});
      end
      mon_prev = tx_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v,
                           input logic dbg_chk, input logic [7:0] dbg_exp);
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx_i = stop_v;
    repeat (BIT / 2 + 12) @(negedge clk);
    if (dbg_chk) chk("wr_latency", 32'(debug_o), 32'(dbg_exp));
    repeat (BIT - BIT / 2 - 12) @(negedge clk);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] exp;
    logic [8:0] got;
    logic       in_range;
    int         waited;
    in_range = (int'(a) < NREGS);
    tx_edges = 0;
    if (c == 8'h01 && in_range) model[a[3:0]] = d;
    exp = in_range ? model[a[3:0]] : 8'h00;
    send_byte(c, 1'b1, 1'b0, 8'h00);
    send_byte(a, 1'b1, 1'b0, 8'h00);
    send_byte(d, 1'b1, (c == 8'h01) && (a == 8'h00), model[0]);
    if (c == 8'h02) begin
      waited = 0;
      while (rxq.size() == 0 && waited < 12 * BIT) begin
        @(negedge clk);
        waited++;
      end
      chk("rd_arrive", 32'(rxq.size() > 0), 32'd1);
      if (rxq.size() > 0) begin
        got = rxq.pop_front();
        chk("rd_data", 32'(got), 32'({1'b1, exp}));
      end
      repeat (BIT) @(negedge clk);
      chk("rd_one_byte", 32'(tx_edges), 32'd1);
    end else begin
      chk("no_tx", 32'(tx_edges), 32'd0);
    end
    chk("debug", 32'(debug_o), 32'(model[0]));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int waited;
    logic [7:0] c, a, d;
    int r;

    rst_raw = 1'b0;
    rx_i    = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    #1 rst_raw = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || debug_o !== 8'h00) bad++;
    end
    chk("reset_hold", 32'(bad), 32'd0);
    rst_raw = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_tx", 32'(tx_o), 32'd1);
    chk("reset_dbg", 32'(debug_o), 32'd0);

    do_cmd(8'h01, 8'h00, 8'hA1);
    do_cmd(8'h02, 8'h00, 8'h00);
    do_cmd(8'h01, 8'h03, 8'h5C);
    do_cmd(8'h02, 8'h03, 8'h00);
    do_cmd(8'h02, 8'h20, 8'h00);
    do_cmd(8'h07, 8'h00, 8'hFF);
    do_cmd(8'h02, 8'h00, 8'h00);

    // Byte with a low stop bit must vanish without shifting the frame count.
    tx_edges = 0;
    send_byte(8'h01, 1'b0, 1'b0, 8'h00);
    repeat (BIT) @(negedge clk);
    chk("bad_stop_no_tx", 32'(tx_edges), 32'd0);
    do_cmd(8'h01, 8'h05, 8'h33);
    do_cmd(8'h02, 8'h05, 8'h00);

    for (int k = 0; k < 14; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      c = 8'h01;
      else if (r < 8) c = 8'h02;
      else            c = 8'(3 + $urandom_range(0, 250));
      if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(16, 255));
      else                           a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      do_cmd(c, a, d);
    end

    // Reset asserted while a read response is on the line.
    do_cmd(8'h01, 8'h00, 8'hC3);
    send_byte(8'h02, 1'b1, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 1'b0, 8'h00);
    send_byte(8'h00, 1'b1, 1'b0, 8'h00);
    waited = 0;
    while (tx_o !== 1'b0 && waited < 4 * BIT) begin
      @(negedge clk);
      waited++;
    end
    chk("tx_started", 32'(tx_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_raw = 1'b1;
    #1;
    chk("rst_mid_tx", 32'(tx_o), 32'd1);
    chk("rst_mid_dbg", 32'(debug_o), 32'd0);
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    repeat (20) @(negedge clk);
    rst_raw = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    rxq.delete();

    do_cmd(8'h02, 8'h03, 8'h00);
    do_cmd(8'h01, 8'h00, 8'h6E);
    do_cmd(8'h02, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
